// File: rtl/pix_sink_pkg.sv
// pix_sink_pkg: shared state encoding and constants for the frame sink
package pix_sink_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int FRAME_PIXELS_DEF = 1024;
endpackage

// File: rtl/pix_sink_ram.sv
// pix_sink_ram: 32-bit simple dual-port frame RAM, read returns old word on collision
module pix_sink_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data
);
    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rd_data;

    // write port; contents are deliberately never cleared
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    end

    // registered read sees the pre-write contents on a same-address collision
    always_ff @(posedge clk) begin
        if (!resetn) r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/pix_frame_sink.sv
// pix_frame_sink: captures one frame of pixels, packs 4 per word into RAM; optional PIX_SINK_CHECKSUM_EN adds o_checksum
module pix_frame_sink
    import pix_sink_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int ADDR_W = 8,
    parameter int CNT_W = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [7:0]        i_pixel_in,
    input  logic              i_valid_in,
    output logic              o_ready_out,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_aborted,
    output logic [CNT_W-1:0]  o_pixel_count,
    output logic [7:0]        o_frame_cnt,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data,
    output logic              o_rd_valid
`ifdef PIX_SINK_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);
    state_t            r_state, w_next;
    logic [1:0]        r_idx;
    logic [31:0]       r_word, w_asm, w_wdata;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_pixel_count;
    logic [7:0]        r_frame_cnt;
    logic              r_aborted, r_rd_valid;
    logic              w_xfer, w_last, w_abort, w_we, w_arm;
    logic [2:0]        w_fill;

    assign o_ready_out   = r_state == CAPTURE;
    assign o_busy        = r_state == CAPTURE;
    assign o_frame_done  = r_state == DONE;
    assign o_aborted     = r_aborted;
    assign o_pixel_count = r_pixel_count;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_rd_valid    = r_rd_valid;
    assign w_xfer  = i_valid_in && o_ready_out;
    assign w_last  = w_xfer && r_pixel_count == CNT_W'(FRAME_PIXELS - 1);
    assign w_abort = r_state == CAPTURE && !i_start && !w_last;
    assign w_arm   = r_state == IDLE && i_start;
    assign w_fill  = {1'b0, r_idx} + 3'(w_xfer);
    assign w_we    = resetn && ((w_xfer && r_idx == 2'd3) || (w_abort && (r_idx != 2'd0 || w_xfer)));

    // next state: completion beats a simultaneous start drop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? CAPTURE : IDLE;
            CAPTURE: w_next = w_last ? DONE : (!i_start ? IDLE : CAPTURE);
            DONE:    w_next = i_start ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // assemble the word with the current pixel and zero lanes not yet filled
    always_comb begin
        w_asm = r_word;
        if (w_xfer) w_asm[{r_idx, 3'b000} +: 8] = i_pixel_in;
        w_wdata = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++)
            w_wdata[k*8 +: 8] = (3'(k) < w_fill) ? w_asm[k*8 +: 8] : 8'h00;
    end

    // state, packer, pointers and counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_word        <= '0;
            r_wr_ptr      <= '0;
            r_pixel_count <= '0;
            r_frame_cnt   <= '0;
            r_aborted     <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= i_rd_en;
            if (w_arm) begin
                r_idx         <= '0;
                r_wr_ptr      <= '0;
                r_pixel_count <= '0;
                r_aborted     <= 1'b0;
            end
            if (w_xfer) begin
                r_word        <= w_asm;
                r_idx         <= r_idx + 2'd1;
                r_pixel_count <= r_pixel_count + 1'b1;
            end
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_last) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_abort) r_aborted <= 1'b1;
        end
    end

`ifdef PIX_SINK_CHECKSUM_EN
    logic [15:0] r_checksum;
    assign o_checksum = r_checksum;

    // wrapping sum of accepted pixels, restarted on each arm
    always_ff @(posedge clk) begin
        if (!resetn) r_checksum <= '0;
        else if (w_arm) r_checksum <= '0;
        else if (w_xfer) r_checksum <= r_checksum + {8'h00, i_pixel_in};
    end
`endif

    pix_sink_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .resetn    (resetn),
        .i_we      (w_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wdata),
        .i_rd_en   (i_rd_en),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );
endmodule

// File: tb/tb_pix_frame_sink.sv
// tb_pix_frame_sink: directed self-checking bench for pix_frame_sink
module tb_pix_frame_sink;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        valid = 1'b0;
    logic        ready, busy, done, aborted, rd_valid;
    logic [10:0] pcount;
    logic [7:0]  fcnt;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = 8'h00;
    logic [31:0] rd_data;
`ifdef PIX_SINK_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pix_frame_sink dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_start       (start),
        .i_pixel_in    (pixel),
        .i_valid_in    (valid),
        .o_ready_out   (ready),
        .o_busy        (busy),
        .o_frame_done  (done),
        .o_aborted     (aborted),
        .o_pixel_count (pcount),
        .o_frame_cnt   (fcnt),
        .i_rd_en       (rd_en),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid)
`ifdef PIX_SINK_CHECKSUM_EN
        ,
        .o_checksum    (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        rd_en = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_v"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        logic [10:0] iv;
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_abort", {31'd0, aborted}, 32'd0);
        chk("rst_pcount", {21'd0, pcount}, 32'd0);
        chk("rst_fcnt", {24'd0, fcnt}, 32'd0);
        chk("rst_rdata", rd_data, 32'd0);
        chk("rst_rvalid", {31'd0, rd_valid}, 32'd0);
        resetn = 1'b1;
        step();

        start = 1'b1;
        step();
        chk("ramp_busy", {31'd0, busy}, 32'd1);
        valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            iv = 11'(i);
            pixel = iv[7:0];
            step();
        end
        chk("ramp_ready_drop", {31'd0, ready}, 32'd0);
        chk("ramp_done", {31'd0, done}, 32'd1);
        pixel = 8'hAA;
        step();
        step();
        chk("ramp_pcount", {21'd0, pcount}, 32'd1024);
        chk("ramp_fcnt", {24'd0, fcnt}, 32'd1);
        chk("ramp_abort", {31'd0, aborted}, 32'd0);
`ifdef PIX_SINK_CHECKSUM_EN
        chk("ramp_csum", {16'd0, checksum}, 32'h0000FE00);
`endif
        valid = 1'b0;
        rd("ramp_w0", 8'd0, 32'h03020100);
        rd("ramp_w1", 8'd1, 32'h07060504);
        rd("ramp_w255", 8'd255, 32'hFFFEFDFC);

        step();
        step();
        chk("rearm_hold_done", {31'd0, done}, 32'd1);
        chk("rearm_hold_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        step();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_pcount", {21'd0, pcount}, 32'd1024);

        start = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            pixel = 8'h11 * 8'(i + 1);
            step();
        end
        valid = 1'b0;
        start = 1'b0;
        step();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flag", {31'd0, aborted}, 32'd1);
        chk("abort_pcount", {21'd0, pcount}, 32'd6);
        chk("abort_fcnt", {24'd0, fcnt}, 32'd1);
        rd("abort_w0", 8'd0, 32'h44332211);
        rd("abort_w1", 8'd1, 32'h00006655);
        rd("abort_w2", 8'd2, 32'h0B0A0908);

        start = 1'b1;
        valid = 1'b1;
        pixel = 8'hEE;
        step();
        chk("gap_abort_clr", {31'd0, aborted}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            pixel = 8'h10 + 8'(i);
            step();
            valid = 1'b0;
            pixel = 8'hEE;
            step();
        end
        chk("gap_pcount", {21'd0, pcount}, 32'd4);
        start = 1'b0;
        step();
        chk("gap_abort", {31'd0, aborted}, 32'd1);
        rd("gap_w0", 8'd0, 32'h13121110);
        rd("gap_w1", 8'd1, 32'h00006655);

        start = 1'b1;
        step();
        for (int i = 0; i < 1024; i++) begin
            iv = 11'(i);
            valid = 1'b1;
            pixel = ~iv[7:0];
            rd_en = (i == 3);
            rd_addr = 8'd0;
            if (i == 1023) start = 1'b0;
            step();
            if (i == 3) chk("collide_old", rd_data, 32'h13121110);
        end
        rd_en = 1'b0;
        valid = 1'b0;
        chk("f2_done", {31'd0, done}, 32'd1);
        chk("f2_abort", {31'd0, aborted}, 32'd0);
        chk("f2_fcnt", {24'd0, fcnt}, 32'd2);
        step();
        chk("f2_idle", {31'd0, done}, 32'd0);
        rd("f2_w0", 8'd0, 32'hFCFDFEFF);
        rd("f2_w255", 8'd255, 32'h00010203);

        start = 1'b1;
        step();
        for (int i = 0; i < 503; i++) begin
            valid = 1'b1;
            pixel = 8'hC0;
            step();
        end
        pixel = 8'h99;
        resetn = 1'b0;
        step();
        start = 1'b0;
        valid = 1'b0;
        chk("mrst_ready", {31'd0, ready}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_pcount", {21'd0, pcount}, 32'd0);
        chk("mrst_fcnt", {24'd0, fcnt}, 32'd0);
        chk("mrst_rdata", rd_data, 32'd0);
`ifdef PIX_SINK_CHECKSUM_EN
        chk("mrst_csum", {16'd0, checksum}, 32'd0);
`endif
        resetn = 1'b1;
        step();
        rd("mrst_w0", 8'd0, 32'hC0C0C0C0);
        rd("mrst_w125", 8'd125, 32'h08090A0B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
